config_loader: RTL and testbench

Byte-stream configuration loader that drives the tile configuration bus (`config_en`, `config_addr`, `config_data`) shared by all PE tiles in the fabric. It accepts a framed bitstream from the host or boot interface over a valid/ready byte channel. It decodes 4-byte frames and issues one single-cycle configuration write per frame. It reports completion, protocol errors, and the number of writes issued.

---
 rtl/config_loader.sv | 196 +++++++++++++++++++
 tb/tb_config_loader.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
//
// Byte-stream configuration loader. Consumes 4-byte frames from a valid/ready
// byte channel and issues one single-cycle write per frame onto the tile
// configuration bus shared by all PE tiles.
//
// Frame: B0 = address, B1 = {op[1:0], data[21:16]}, B2 = data[15:8],
//        B3 = data[7:0].  op 00 = write, 11 = end of configuration,
//        01/10 = illegal.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse; begins a load from IDLE/DONE/ERR
//   in_data, in_valid   stream byte and its qualifier
//   in_ready            loader accepts a byte (pure decode of the state)
//   config_en           one-cycle write strobe to the tiles
//   config_addr         target tile address (registered, held between writes)
//   config_data         22-bit configuration word (registered, held)
//   busy                a load is in progress
//   done                end frame seen (sticky until start/reset)
//   error               protocol error seen (sticky until start/reset)
//   frame_count         writes issued since the last start (saturating)
// -----------------------------------------------------------------------------
module config_loader #(
    parameter int NUM_TILES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        config_en,
    output logic [7:0]  config_addr,
    output logic [21:0] config_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_D1,
        S_D2,
        S_D3,
        S_ISSUE,
        S_DONE,
        S_ERR
    } state_t;

    // One bit wider than a byte so NUM_TILES = 256 accepts every address.
    localparam logic [8:0] TILE_LIMIT = 9'(NUM_TILES);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_END   = 2'b11;

    state_t      state_q,       state_d;
    logic [7:0]  addr_q,        addr_d;
    logic [1:0]  op_q,          op_d;
    logic [5:0]  data_hi_q,     data_hi_d;
    logic [7:0]  data_mid_q,    data_mid_d;
    logic [7:0]  cfg_addr_q,    cfg_addr_d;
    logic [21:0] cfg_data_q,    cfg_data_d;
    logic        done_q,        done_d;
    logic        error_q,       error_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic accept;

    // Handshake and strobe are decoded from the registered state only, so
    // reset drops them immediately and in_ready never depends on in_valid.
    assign in_ready = (state_q == S_ADDR) || (state_q == S_D1) ||
                      (state_q == S_D2)   || (state_q == S_D3);
    assign accept    = in_valid && in_ready;
    assign config_en = (state_q == S_ISSUE);
    assign busy      = in_ready || config_en;

    assign config_addr = cfg_addr_q;
    assign config_data = cfg_data_q;
    assign done        = done_q;
    assign error       = error_q;
    assign frame_count = frame_count_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        op_d          = op_q;
        data_hi_d     = data_hi_q;
        data_mid_d    = data_mid_q;
        cfg_addr_d    = cfg_addr_q;
        cfg_data_d    = cfg_data_q;
        done_d        = done_q;
        error_d       = error_q;
        frame_count_d = frame_count_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d       = S_ADDR;
                    done_d        = 1'b0;
                    error_d       = 1'b0;
                    frame_count_d = '0;
                end
            end

            S_ADDR: begin
                if (accept) begin
                    if ({1'b0, in_data} < TILE_LIMIT) begin
                        addr_d  = in_data;
                        state_d = S_D1;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end

            S_D1: begin
                if (accept) begin
                    op_d      = in_data[7:6];
                    data_hi_d = in_data[5:0];
                    if ((in_data[7:6] == OP_WRITE) || (in_data[7:6] == OP_END)) begin
                        state_d = S_D2;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end

            S_D2: begin
                if (accept) begin
                    data_mid_d = in_data;
                    state_d    = S_D3;
                end
            end

            S_D3: begin
                if (accept) begin
                    if (op_q == OP_END) begin
                        // Payload of an end frame is consumed but discarded.
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        // The bus registers load on entry to ISSUE so address
                        // and data are valid in the same cycle as config_en.
                        cfg_addr_d = addr_q;
                        cfg_data_d = {data_hi_q, data_mid_q, in_data};
                        state_d    = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (frame_count_q != 16'hFFFF) begin
                    frame_count_d = frame_count_q + 16'd1;
                end
                state_d = S_ADDR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            op_q          <= '0;
            data_hi_q     <= '0;
            data_mid_q    <= '0;
            cfg_addr_q    <= '0;
            cfg_data_q    <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            op_q          <= op_d;
            data_hi_q     <= data_hi_d;
            data_mid_q    <= data_mid_d;
            cfg_addr_q    <= cfg_addr_d;
            cfg_data_q    <= cfg_data_d;
            done_q        <= done_d;
            error_q       <= error_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// -----------------------------------------------------------------------------
// tb_config_loader
//
// Self-checking bench for config_loader: a table of single-frame vectors,
// hand-written multi-cycle sequences (timing, back-to-back, stalls, error
// recovery, reset mid-frame, start while busy) and randomized loads checked
// against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_config_loader;

    localparam int NUM_TILES = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        config_en;
    logic [7:0]  config_addr;
    logic [21:0] config_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] frame_count;

    config_loader #(.NUM_TILES(NUM_TILES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .config_en   (config_en),
        .config_addr (config_addr),
        .config_data (config_data),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    // Observed write strobes, sampled on the falling edge.
    logic [7:0]  obs_addr[$];
    logic [21:0] obs_data[$];
    int          obs_cyc[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1 && config_en === 1'b1) begin
            obs_addr.push_back(config_addr);
            obs_data.push_back(config_data);
            obs_cyc.push_back(cyc);
        end
    end

    int n_acc    = 0;
    int last_acc = 0;

    // Reference model results.
    logic [7:0]  exp_addr[$];
    logic [21:0] exp_data[$];
    logic        exp_done;
    logic        exp_err;
    int          exp_cons;

    typedef struct {
        logic [31:0] bytes;
        int          npulse;
        logic [7:0]  addr;
        logic [21:0] data;
        logic        done;
        logic        err;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic clr_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        n_acc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called on a falling edge; returns on the falling edge after the start edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte; returns on the falling edge after it is accepted, or
    // with ok = 0 after 20 cycles without acceptance.
    task automatic send_byte(input logic [7:0] b, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        while (!ok && n < 20) begin
            if (in_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
            if (ok) begin
                n_acc++;
                last_acc = cyc;
            end
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] fr, input int gap);
        bit ok;
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            repeat (gap) @(negedge clk);
            b = fr[31 - 8*i -: 8];
            send_byte(b, ok);
            if (!ok) return;
        end
    endtask

    // Frame-level reference: walk the byte list four bytes at a time.
    task automatic model(input logic [7:0] bs[$]);
        int i;
        bit stop;
        logic [7:0] b0, b1, b2, b3;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_cons = 0;
        i    = 0;
        stop = 1'b0;
        while (!stop && i + 4 <= bs.size()) begin
            b0 = bs[i];
            b1 = bs[i+1];
            b2 = bs[i+2];
            b3 = bs[i+3];
            if (int'(b0) >= NUM_TILES) begin
                exp_err = 1'b1; exp_cons = i + 1; stop = 1'b1;
            end else if (b1[7:6] == 2'b01 || b1[7:6] == 2'b10) begin
                exp_err = 1'b1; exp_cons = i + 2; stop = 1'b1;
            end else if (b1[7:6] == 2'b11) begin
                exp_done = 1'b1; exp_cons = i + 4; stop = 1'b1;
            end else begin
                exp_addr.push_back(b0);
                exp_data.push_back({b1[5:0], b2, b3});
                i = i + 4;
                exp_cons = i;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        logic [7:0] bs[$];
        logic [7:0] a;
        logic [7:0] op_b;
        int r, nmin;

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        vecs[0] = '{32'h032ABCDE, 1, 8'h03, 22'h2ABCDE, 1'b0, 1'b0, 16'd1};
        vecs[1] = '{32'h0F3FFFFF, 1, 8'h0F, 22'h3FFFFF, 1'b0, 1'b0, 16'd1};
        vecs[2] = '{32'h10000000, 0, 8'h00, 22'h000000, 1'b0, 1'b1, 16'd0};
        vecs[3] = '{32'hFF123456, 0, 8'h00, 22'h000000, 1'b0, 1'b1, 16'd0};
        vecs[4] = '{32'h05401122, 0, 8'h00, 22'h000000, 1'b0, 1'b1, 16'd0};
        vecs[5] = '{32'h05801122, 0, 8'h00, 22'h000000, 1'b0, 1'b1, 16'd0};
        vecs[6] = '{32'h00C00000, 0, 8'h00, 22'h000000, 1'b1, 1'b0, 16'd0};
        vecs[7] = '{32'h0A050607, 1, 8'h0A, 22'h050607, 1'b0, 1'b0, 16'd1};

        // Reset state, both while held and after release.
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_config_en", 32'(config_en), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_addr", 32'(config_addr), 32'd0);
        chk("rst_data", 32'(config_data), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);

        // Table-driven single frames.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            clr_obs();
            pulse_start();
            send_frame(vecs[v].bytes, 0);
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d_pulses", v), 32'(obs_addr.size()), 32'(vecs[v].npulse));
            chk($sformatf("vec%0d_addr", v), 32'(config_addr), 32'(vecs[v].addr));
            chk($sformatf("vec%0d_data", v), 32'(config_data), 32'(vecs[v].data));
            chk($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].done));
            chk($sformatf("vec%0d_error", v), 32'(error), 32'(vecs[v].err));
            chk($sformatf("vec%0d_fc", v), 32'(frame_count), 32'(vecs[v].fc));
            chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(!(vecs[v].done || vecs[v].err)));
        end

        // Single write: exact timing around the strobe.
        do_reset();
        clr_obs();
        pulse_start();
        chk("sw_busy_after_start", 32'(busy), 32'd1);
        chk("sw_ready_after_start", 32'(in_ready), 32'd1);
        send_frame(32'h032ABCDE, 0);
        chk("sw_en", 32'(config_en), 32'd1);
        chk("sw_addr", 32'(config_addr), 32'h03);
        chk("sw_data", 32'(config_data), 32'h2ABCDE);
        chk("sw_fc_during", 32'(frame_count), 32'd0);
        chk("sw_ready_during", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("sw_en_after", 32'(config_en), 32'd0);
        chk("sw_fc_after", 32'(frame_count), 32'd1);
        chk("sw_ready_after", 32'(in_ready), 32'd1);
        chk("sw_pulse_cycle", 32'(obs_cyc.size() > 0 ? obs_cyc[0] : -1), 32'(last_acc));

        // Back-to-back frames then end frame.
        do_reset();
        clr_obs();
        pulse_start();
        send_frame(32'h01000011, 0);
        send_frame(32'h021555AA, 0);
        send_frame(32'h0E3F00FF, 0);
        send_frame(32'h00C00000, 0);
        @(negedge clk);
        chk("b2b_pulses", 32'(obs_addr.size()), 32'd3);
        chk("b2b_space01", 32'(obs_cyc[1] - obs_cyc[0]), 32'd5);
        chk("b2b_space12", 32'(obs_cyc[2] - obs_cyc[1]), 32'd5);
        chk("b2b_addr1", 32'(obs_addr[1]), 32'h02);
        chk("b2b_data1", 32'(obs_data[1]), 32'h1555AA);
        chk("b2b_addr2", 32'(obs_addr[2]), 32'h0E);
        chk("b2b_data2", 32'(obs_data[2]), 32'h3F00FF);
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_fc", 32'(frame_count), 32'd3);
        chk("b2b_ready", 32'(in_ready), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd0);

        // Stall of 7 idle cycles between B1 and B2.
        do_reset();
        clr_obs();
        pulse_start();
        send_byte(8'h05, ok);
        send_byte(8'h1A, ok);
        repeat (7) @(negedge clk);
        send_byte(8'h77, ok);
        send_byte(8'h88, ok);
        repeat (2) @(negedge clk);
        chk("stall_pulses", 32'(obs_addr.size()), 32'd1);
        chk("stall_addr", 32'(config_addr), 32'h05);
        chk("stall_data", 32'(config_data), 32'h1A7788);
        chk("stall_accepts", 32'(n_acc), 32'd4);

        // Illegal op after a good write, then a fresh start clears status.
        do_reset();
        clr_obs();
        pulse_start();
        send_frame(32'h01000001, 0);
        send_frame(32'h02401234, 0);
        chk("op_err_error", 32'(error), 32'd1);
        chk("op_err_fc", 32'(frame_count), 32'd1);
        chk("op_err_pulses", 32'(obs_addr.size()), 32'd1);
        pulse_start();
        chk("restart_error", 32'(error), 32'd0);
        chk("restart_fc", 32'(frame_count), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);

        // Reset mid-frame after B2.
        do_reset();
        clr_obs();
        pulse_start();
        send_frame(32'h07010203, 0);
        send_byte(8'h09, ok);
        send_byte(8'h2A, ok);
        send_byte(8'hBC, ok);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 32'(config_en), 32'd0);
        chk("mid_rst_addr", 32'(config_addr), 32'd0);
        chk("mid_rst_data", 32'(config_data), 32'd0);
        chk("mid_rst_fc", 32'(frame_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h09, ok);
        chk("mid_rst_no_accept", 32'(ok), 32'd0);
        pulse_start();
        send_frame(32'h092ABCDE, 0);
        repeat (2) @(negedge clk);
        chk("mid_rst_reload_addr", 32'(config_addr), 32'h09);
        chk("mid_rst_reload_data", 32'(config_data), 32'h2ABCDE);
        chk("mid_rst_reload_fc", 32'(frame_count), 32'd1);

        // start pulsed in D2 is ignored.
        do_reset();
        clr_obs();
        pulse_start();
        send_frame(32'h01000001, 0);
        send_byte(8'h04, ok);
        send_byte(8'h3C, ok);
        pulse_start();
        send_byte(8'h5A, ok);
        send_byte(8'hA5, ok);
        repeat (2) @(negedge clk);
        chk("busy_start_fc", 32'(frame_count), 32'd2);
        chk("busy_start_addr", 32'(config_addr), 32'h04);
        chk("busy_start_data", 32'(config_data), 32'h3C5AA5);
        chk("busy_start_pulses", 32'(obs_addr.size()), 32'd2);

        // Randomized loads against the frame-level model.
        do_reset();
        for (int ld = 0; ld < 25; ld++) begin
            bs.delete();
            for (int f = 0; f < 8; f++) begin
                r = $urandom_range(0, 19);
                a = 8'($urandom_range(0, 17));
                if (r < 15)      op_b = 8'h00;
                else if (r < 17) op_b = 8'hC0;
                else if (r < 18) op_b = 8'h40;
                else if (r < 19) op_b = 8'h80;
                else             op_b = 8'h00;
                bs.push_back(a);
                bs.push_back(op_b | 8'($urandom_range(0, 63)));
                bs.push_back(8'($urandom_range(0, 255)));
                bs.push_back(8'($urandom_range(0, 255)));
            end
            bs.push_back(8'h00);
            bs.push_back(8'hC0);
            bs.push_back(8'h00);
            bs.push_back(8'h00);
            model(bs);

            clr_obs();
            pulse_start();
            foreach (bs[k]) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_byte(bs[k], ok);
                if (!ok) break;
            end
            repeat (2) @(negedge clk);

            chk($sformatf("rnd%0d_consumed", ld), 32'(n_acc), 32'(exp_cons));
            chk($sformatf("rnd%0d_writes", ld), 32'(obs_addr.size()), 32'(exp_addr.size()));
            nmin = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
            for (int i = 0; i < nmin; i++) begin
                chk($sformatf("rnd%0d_w%0d_addr", ld, i), 32'(obs_addr[i]), 32'(exp_addr[i]));
                chk($sformatf("rnd%0d_w%0d_data", ld, i), 32'(obs_data[i]), 32'(exp_data[i]));
            end
            chk($sformatf("rnd%0d_done", ld), 32'(done), 32'(exp_done));
            chk($sformatf("rnd%0d_error", ld), 32'(error), 32'(exp_err));
            chk($sformatf("rnd%0d_fc", ld), 32'(frame_count), 32'(exp_addr.size()));
            chk($sformatf("rnd%0d_busy", ld), 32'(busy), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
